// File: rtl/idu_pkg.sv
// Shared defaults, header layout and FSM state encoding for the instruction fetch unit.
package idu_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_MAX_WORDS  = 4;

    // The instruction length field is the top HDR_LEN_BITS of the header word; length = field + 1.
    localparam int HDR_LEN_BITS   = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        OUT,
        ERR
    } state_t;

endpackage

// File: rtl/idu_instr_fetch.sv
// Instruction fetch: pulls header-prefixed variable-length instructions from a FIFO and presents them on a valid/ready port.
// Optional accepted-instruction counter enabled with macro IDU_INSTR_CNT_EN.
module idu_instr_fetch
    import idu_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int MAX_WORDS  = DEF_MAX_WORDS
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             prog_start,
    input  logic [15:0]                      prog_len,
    output logic                             idu2ifu_rd_rqst,
    input  logic [FIFO_WIDTH-1:0]            fifo_rd_data,
    input  logic                             fifo_empty,
    output logic [FIFO_WIDTH*MAX_WORDS-1:0]  instr_out,
    output logic [2:0]                       instr_len,
    output logic                             instr_valid,
    input  logic                             instr_ready,
    output logic                             done,
    output logic                             err,
    output logic [15:0]                      instr_count
);

    localparam int INSTR_WIDTH = FIFO_WIDTH * MAX_WORDS;

    state_t      state;
    logic [15:0] words_left;
    logic [2:0]  word_idx;
    logic [2:0]  hdr_len;
    logic        accept;
    logic        start_ok;

    always_comb begin
        hdr_len = 3'(fifo_rd_data[FIFO_WIDTH-1 -: HDR_LEN_BITS]) + 3'd1;
    end

    // The read strobe is decoded from state so each word costs only one REQ and one CAPT cycle.
    assign idu2ifu_rd_rqst = (state == REQ) && !fifo_empty;
    assign accept          = instr_valid && instr_ready;
    assign start_ok        = prog_start && ((state == IDLE) || (state == ERR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            words_left  <= '0;
            word_idx    <= '0;
            instr_out   <= '0;
            instr_len   <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (prog_start) begin
                        words_left <= prog_len;
                        word_idx   <= '0;
                        err        <= 1'b0;
                        if (prog_len == 16'd0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!fifo_empty) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (words_left != '0) begin
                        words_left <= words_left - 16'd1;
                    end
                    if (word_idx == '0) begin
                        instr_out <= INSTR_WIDTH'(fifo_rd_data);
                        instr_len <= hdr_len;
                        if (16'(hdr_len) > words_left) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end else if (hdr_len == 3'd1) begin
                            instr_valid <= 1'b1;
                            state       <= OUT;
                        end else begin
                            word_idx <= 3'd1;
                            state    <= REQ;
                        end
                    end else begin
                        instr_out[word_idx*FIFO_WIDTH +: FIFO_WIDTH] <= fifo_rd_data;
                        if (word_idx + 3'd1 == instr_len) begin
                            instr_valid <= 1'b1;
                            word_idx    <= '0;
                            state       <= OUT;
                        end else begin
                            word_idx <= word_idx + 3'd1;
                            state    <= REQ;
                        end
                    end
                end
                OUT: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (words_left == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IDU_INSTR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (start_ok) begin
            instr_count <= '0;
        end else if (accept && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt  = accept ^ start_ok;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_idu_instr_fetch.sv
// Self-checking bench for idu_instr_fetch: FIFO model plus a program-level reference of expected instructions.
module tb_idu_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_start = 1'b0;
    logic [15:0] prog_len = '0;
    logic        rd;
    logic [15:0] fifo_rd_data = '0;
    logic        fifo_empty;
    logic [63:0] instr_out;
    logic [2:0]  instr_len;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        done;
    logic        err;
    logic [15:0] instr_count;
    logic        stall = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_count = 0;

    logic [15:0] pw [0:63];
    logic [63:0] exp_instr [$];
    logic [2:0]  exp_len [$];
    bit          exp_err;
    int          exp_reads;
    int          exp_n;

    idu_instr_fetch #(.FIFO_WIDTH(16), .MAX_WORDS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .prog_start      (prog_start),
        .prog_len        (prog_len),
        .idu2ifu_rd_rqst (rd),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_empty      (fifo_empty),
        .instr_out       (instr_out),
        .instr_len       (instr_len),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .done            (done),
        .err             (err),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = stall || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rd) begin
            fifo_rd_data <= mem[rd_ptr % 1024];
            rd_ptr       <= rd_ptr + 1;
            rd_count     <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(negedge clk);
        prog_len   = len;
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
    endtask

    // Walks the program word list by the header rules and lists the instructions it must yield.
    task automatic build_model(input int plen);
        int p;
        int left;
        int len;
        logic [63:0] v;
        exp_instr.delete();
        exp_len.delete();
        exp_err   = 1'b0;
        exp_reads = 0;
        exp_n     = 0;
        p         = 0;
        left      = plen;
        while (left > 0) begin
            len = int'(pw[p][15:14]) + 1;
            exp_reads++;
            if (len > left) begin
                exp_err = 1'b1;
                break;
            end
            v = '0;
            for (int j = 0; j < len; j++) v[j*16 +: 16] = pw[p+j];
            exp_reads += len - 1;
            exp_instr.push_back(v);
            exp_len.push_back(3'(len));
            p    += len;
            left -= len;
            exp_n++;
        end
    endtask

    task automatic load_fifo(input int plen);
        wr_ptr = rd_ptr;
        for (int i = 0; i < plen; i++) mem[(wr_ptr + i) % 1024] = pw[i];
        wr_ptr = wr_ptr + plen;
    endtask

    task automatic run_prog(input int plen, input bit rand_ready, input bit rand_stall,
                            input int stall_at, input bit hold, input bit glitch, input bit timing);
        int rd0, cyc, done_seen, done_cyc, stall_cnt, hold_left, extra;
        bit stalled_once, hold_on, finished;
        logic [63:0] snap;
        done_seen = 0; done_cyc = 0; stall_cnt = 0; extra = 0; snap = '0;
        stalled_once = 1'b0; hold_on = 1'b0; finished = 1'b0;
        hold_left = hold ? 10 : 0;
        build_model(plen);
        load_fifo(plen);
        rd0 = rd_count;
        pulse_start(16'(plen));
        check("start_clears_err", err, 1'b0);
        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stall_cnt > 0) begin
                if (stall_cnt == 5) snap = instr_out;
                else check("stall_data", instr_out, snap);
                check("stall_rd", rd, 1'b0);
                stall_cnt--;
                if (stall_cnt == 0) stall = 1'b0;
            end else if (stall_at > 0 && !stalled_once && (rd_count - rd0) == stall_at) begin
                stall        = 1'b1;
                stall_cnt    = 5;
                stalled_once = 1'b1;
            end else if (rand_stall) begin
                stall = ($urandom_range(0, 3) == 0);
            end
            if (instr_valid) begin
                if (exp_instr.size() == 0) begin
                    check("extra_instr", instr_valid, 1'b0);
                end else begin
                    check("instr_out", instr_out, exp_instr[0]);
                    check("instr_len", instr_len, exp_len[0]);
                end
            end
            if (hold_left > 0 && instr_valid) hold_on = 1'b1;
            if (hold_on && hold_left > 0) begin
                check("hold_valid", instr_valid, 1'b1);
                check("hold_rd", rd, 1'b0);
                instr_ready = 1'b0;
                hold_left--;
                if (hold_left == 0) hold_on = 1'b0;
            end else begin
                instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (instr_valid && instr_ready && exp_instr.size() > 0) begin
                void'(exp_instr.pop_front());
                void'(exp_len.pop_front());
            end
            if (glitch && cyc == 4) begin
                prog_start = 1'b1;
                prog_len   = 16'd1;
            end else begin
                prog_start = 1'b0;
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                finished = 1'b1;
            end
            if (err && exp_err) finished = 1'b1;
        end
        prog_start = 1'b0;
        stall      = 1'b0;
        check("timeout", finished, 1'b1);
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen++;
            if (instr_valid) extra++;
        end
        check("done_pulses", 64'(done_seen), exp_err ? 64'd0 : 64'd1);
        check("err", err, exp_err);
        check("reads", 64'(rd_count - rd0), 64'(exp_reads));
        check("left_instrs", 64'(exp_instr.size()), 64'd0);
        check("trailing_valid", 64'(extra), 64'd0);
        if (timing) check("cadence", 64'(done_cyc), 64'(2 * plen + exp_n));
`ifdef IDU_INSTR_CNT_EN
        check("instr_count", instr_count, 16'(exp_n));
`else
        check("instr_count", instr_count, 16'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr_out"}, instr_out, 64'd0);
        check({tag, "_instr_len"}, instr_len, 3'd0);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_rd"}, rd, 1'b0);
        check({tag, "_count"}, instr_count, 16'd0);
    endtask

    initial begin
        int rd0;
        int plen;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two instructions: {AAAA,4001} then {0002}, minimum cadence.
        pw[0] = 16'h4001; pw[1] = 16'hAAAA; pw[2] = 16'h0002;
        run_prog(3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Zero-length program.
        rd0 = rd_count;
        pulse_start(16'd0);
        check("zero_len_done", done, 1'b1);
        @(negedge clk);
        check("zero_len_done_end", done, 1'b0);
        check("zero_len_reads", 64'(rd_count - rd0), 64'd0);

        // FIFO empty for 5 cycles after the header of a 4-word instruction.
        pw[0] = 16'hC111; pw[1] = 16'h2222; pw[2] = 16'h3333; pw[3] = 16'h4444; pw[4] = 16'h0005;
        run_prog(5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        // Ready held low 10 cycles in OUT, with a prog_start pulse while busy.
        pw[0] = 16'h4001; pw[1] = 16'hAAAA; pw[2] = 16'h8003; pw[3] = 16'hBBBB; pw[4] = 16'hCCCC;
        run_prog(5, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);

        // Header asks for 4 words with only 2 left: error, no further reads.
        pw[0] = 16'hC000; pw[1] = 16'h1234;
        run_prog(2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Reset while capturing the second word.
        pw[0] = 16'h4001; pw[1] = 16'hAAAA; pw[2] = 16'h0002;
        load_fifo(3);
        rd0 = rd_count;
        instr_ready = 1'b1;
        pulse_start(16'd3);
        for (int i = 0; i < 50; i++) begin
            if ((rd_count - rd0) == 2) break;
            @(negedge clk);
        end
        check("rst_reach_word2", 64'(rd_count - rd0), 64'd2);
        check("rst_pre_hdr", instr_out, 64'h4001);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;

        // Three instructions counted, clean fetch after reset.
        pw[0] = 16'h0001; pw[1] = 16'h4002; pw[2] = 16'h0102; pw[3] = 16'h0003;
        run_prog(4, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Randomized programs, random ready and FIFO stalls.
        for (int t = 0; t < 20; t++) begin
            plen = int'($urandom_range(1, 12));
            for (int i = 0; i < plen; i++) pw[i] = 16'($urandom);
            run_prog(plen, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
